// File: rtl/bus_cycle_controller.sv
// Local bus cycle controller: region decode, wait-state/external-ack DSACK
// generation and bus error on external error or watchdog timeout.
module bus_cycle_controller #(
    parameter int unsigned                           NUM_REGIONS    = 4,
    parameter int unsigned                           ADDR_BITS      = 4,
    parameter int unsigned                           WAIT_BITS      = 4,
    parameter logic [NUM_REGIONS*ADDR_BITS-1:0]      REGION_BASE    = {4'hA, 4'h7, 4'h2, 4'h0},
    parameter logic [NUM_REGIONS*ADDR_BITS-1:0]      REGION_MASK    = {4'hC, 4'hF, 4'hF, 4'hF},
    parameter logic [NUM_REGIONS*WAIT_BITS-1:0]      REGION_WAITS   = {4'd0, 4'd3, 4'd2, 4'd0},
    parameter logic [NUM_REGIONS*2-1:0]              REGION_PORT    = {2'b00, 2'b10, 2'b10, 2'b00},
    parameter logic [NUM_REGIONS-1:0]                REGION_EXTACK  = 4'b1000,
    parameter int unsigned                           TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_as,
    input  logic                   cpu_write,
    input  logic [ADDR_BITS-1:0]   cpu_address_high,
    output logic [NUM_REGIONS-1:0] region_select,
    output logic [1:0]             cpu_dsack,
    output logic                   cpu_dsack_oe,
    output logic                   cpu_berr,
    input  logic                   ext_ack,
    input  logic                   ext_berr,
    output logic                   cycle_active,
    output logic                   timeout_event
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BERR, S_RELEASE} state_e;

    state_e                 state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [1:0]             dsack_q, dsack_d, port_q, port_d;
    logic                   oe_q, oe_d, berr_q, berr_d;
    logic                   active_q, active_d, evt_q, evt_d;
    logic                   hit_q, hit_d, ext_q, ext_d;
    logic [WAIT_BITS-1:0]   wcnt_q, wcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   ext_ack_q, ext_berr_q;

    logic                   dec_hit, dec_ext, ack, err;
    logic [NUM_REGIONS-1:0] dec_sel;
    logic [WAIT_BITS-1:0]   dec_wait;
    logic [1:0]             dec_port;
    logic                   unused_write;

    assign unused_write = cpu_write;

    // Scan from the top index down so the lowest matching region overrides.
    always_comb begin
        dec_hit  = 1'b0;
        dec_ext  = 1'b0;
        dec_sel  = '1;
        dec_wait = '0;
        dec_port = 2'b11;
        for (int unsigned i = NUM_REGIONS; i != 0; i--) begin
            if ((cpu_address_high & ADDR_BITS'(REGION_MASK >> (ADDR_BITS*(i-1)))) ==
                (ADDR_BITS'(REGION_BASE >> (ADDR_BITS*(i-1))) &
                 ADDR_BITS'(REGION_MASK >> (ADDR_BITS*(i-1))))) begin
                dec_hit  = 1'b1;
                dec_sel  = ~(NUM_REGIONS'(1) << (i-1));
                dec_wait = WAIT_BITS'(REGION_WAITS >> (WAIT_BITS*(i-1)));
                dec_port = 2'(REGION_PORT >> (2*(i-1)));
                dec_ext  = 1'(REGION_EXTACK >> (i-1));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dsack_d = dsack_q;
        oe_d    = oe_q;
        berr_d  = berr_q;
        evt_d   = 1'b0;
        hit_d   = hit_q;
        ext_d   = ext_q;
        port_d  = port_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        ack     = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cpu_as) begin
                    sel_d   = dec_sel;
                    hit_d   = dec_hit;
                    ext_d   = dec_ext;
                    port_d  = dec_port;
                    wcnt_d  = dec_wait;
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_as) begin
                    sel_d   = '1;
                    state_d = S_RELEASE;
                end else begin
                    if (hit_q && ext_q) begin
                        err = !ext_berr_q;
                        ack = !ext_ack_q;
                    end else if (hit_q) begin
                        ack = (wcnt_q == '0);
                    end
                    if (wcnt_q != '0)
                        wcnt_d = wcnt_q - 1'b1;
                    if (tcnt_q != TW'(TIMEOUT_CYCLES))
                        tcnt_d = tcnt_q + 1'b1;
                    // Error beats ack, ack beats a coincident watchdog expiry.
                    if (err) begin
                        berr_d  = 1'b0;
                        state_d = S_BERR;
                    end else if (ack) begin
                        dsack_d = port_q;
                        oe_d    = 1'b1;
                        state_d = S_ACK;
                    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        berr_d  = 1'b0;
                        evt_d   = 1'b1;
                        state_d = S_BERR;
                    end
                end
            end
            S_ACK, S_BERR: begin
                if (cpu_as) begin
                    sel_d   = '1;
                    berr_d  = 1'b1;
                    dsack_d = 2'b11;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                dsack_d = 2'b11;
                oe_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '1;
            dsack_q    <= 2'b11;
            oe_q       <= 1'b0;
            berr_q     <= 1'b1;
            active_q   <= 1'b0;
            evt_q      <= 1'b0;
            hit_q      <= 1'b0;
            ext_q      <= 1'b0;
            port_q     <= 2'b11;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            ext_ack_q  <= 1'b1;
            ext_berr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            dsack_q    <= dsack_d;
            oe_q       <= oe_d;
            berr_q     <= berr_d;
            active_q   <= active_d;
            evt_q      <= evt_d;
            hit_q      <= hit_d;
            ext_q      <= ext_d;
            port_q     <= port_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            ext_ack_q  <= ext_ack;
            ext_berr_q <= ext_berr;
        end
    end

    assign region_select = sel_q;
    assign cpu_dsack     = dsack_q;
    assign cpu_dsack_oe  = oe_q;
    assign cpu_berr      = berr_q;
    assign cycle_active  = active_q;
    assign timeout_event = evt_q;

endmodule
